// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the architectural PC and fetches one instruction at a
// time from instruction memory (req/gnt, variable-latency rvalid). It hands each
// instruction to decode over a valid/ready handshake. Redirects from execute
// replace the PC, and any fetch already in flight on the old path is discarded.
// A misaligned redirect target halts the sequencer until reset.

module fetch_sequencer #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req_o,
    output logic [WIDTH-1:0] imem_addr_o,
    input  logic             imem_gnt_i,
    input  logic             imem_rvalid_i,
    input  logic [31:0]      imem_rdata_i,
    output logic             if_valid_o,
    output logic [WIDTH-1:0] if_pc_o,
    output logic [31:0]      if_instr_o,
    input  logic             if_ready_i,
    input  logic             redirect_i,
    input  logic             redirect_sel_i,
    input  logic [WIDTH-1:0] redirect_base_i,
    input  logic [WIDTH-1:0] redirect_imm_i,
    input  logic [WIDTH-1:0] redirect_alu_i,
    output logic             misalign_o,
    output logic             halted_o
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    // JALR targets have bit 0 forced low before use.
    localparam logic [WIDTH-1:0] JALR_MASK = ~(WIDTH'(1));

    state_t           state;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] fetch_pc;
    logic             kill;
    logic             req_q;
    logic             valid_q;
    logic [WIDTH-1:0] if_pc_q;
    logic [31:0]      instr_q;
    logic             misalign_q;
    logic             halted_q;

    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] pc_plus4;
    logic             redirect_take;
    logic             target_misaligned;
    logic             gnt_take;

    // The redirect target is formed from the execute inputs, and the sequential PC is computed here.
    always_comb begin
        target            = redirect_sel_i ? (redirect_alu_i & JALR_MASK)
                                           : (redirect_base_i + redirect_imm_i);
        pc_plus4          = pc + WIDTH'(4);
        redirect_take     = redirect_i && (state != ST_HALT);
        target_misaligned = |target[1:0];
        gnt_take          = req_q && imem_gnt_i;
    end

    assign imem_req_o  = req_q;
    assign imem_addr_o = pc;
    assign if_valid_o  = valid_q;
    assign if_pc_o     = if_pc_q;
    assign if_instr_o  = instr_q;
    assign misalign_o  = misalign_q;
    assign halted_o    = halted_q;

    // Fetch FSM: redirects take priority. The request line is a register, so it
    // goes low for one cycle after reset and never rises in a handshake cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_REQ;
            pc         <= RESET_PC;
            fetch_pc   <= '0;
            kill       <= 1'b0;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
            if_pc_q    <= '0;
            instr_q    <= '0;
            misalign_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            if (redirect_take && target_misaligned) begin
                state      <= ST_HALT;
                req_q      <= 1'b0;
                valid_q    <= 1'b0;
                kill       <= 1'b0;
                misalign_q <= 1'b1;
                halted_q   <= 1'b1;
            end else if (redirect_take) begin
                pc <= target;
                case (state)
                    ST_REQ: begin
                        if (gnt_take) begin
                            fetch_pc <= pc;
                            req_q    <= 1'b0;
                            kill     <= 1'b1;
                            state    <= ST_WAIT;
                        end else begin
                            req_q <= 1'b1;
                        end
                    end
                    ST_WAIT: begin
                        if (imem_rvalid_i) begin
                            kill  <= 1'b0;
                            req_q <= 1'b1;
                            state <= ST_REQ;
                        end else begin
                            kill <= 1'b1;
                        end
                    end
                    ST_HOLD: begin
                        valid_q <= 1'b0;
                        req_q   <= 1'b1;
                        state   <= ST_REQ;
                    end
                    default: begin
                        state <= state;
                    end
                endcase
            end else begin
                case (state)
                    ST_REQ: begin
                        if (gnt_take) begin
                            fetch_pc <= pc;
                            pc       <= pc_plus4;
                            req_q    <= 1'b0;
                            state    <= ST_WAIT;
                        end else begin
                            req_q <= 1'b1;
                        end
                    end
                    ST_WAIT: begin
                        if (imem_rvalid_i) begin
                            if (kill) begin
                                kill  <= 1'b0;
                                req_q <= 1'b1;
                                state <= ST_REQ;
                            end else begin
                                if_pc_q <= fetch_pc;
                                instr_q <= imem_rdata_i;
                                valid_q <= 1'b1;
                                state   <= ST_HOLD;
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (if_ready_i) begin
                            valid_q <= 1'b0;
                            req_q   <= 1'b1;
                            state   <= ST_REQ;
                        end
                    end
                    default: begin
                        req_q    <= 1'b0;
                        valid_q  <= 1'b0;
                        halted_q <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed stimulus around a variable-latency memory model.
// Expected fetch addresses and delivered instructions are queued when the
// stimulus is set up. Monitors pop and compare those entries on every accepted
// request and on every decode handshake.

module tb_fetch_sequencer;

    logic        clk;
    logic        rst;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_instr_o;
    logic        if_ready_i;
    logic        redirect_i;
    logic        redirect_sel_i;
    logic [31:0] redirect_base_i;
    logic [31:0] redirect_imm_i;
    logic [31:0] redirect_alu_i;
    logic        misalign_o;
    logic        halted_o;

    int tests = 0;
    int fails = 0;
    int reqCount = 0;
    int instrCount = 0;
    int memLatency = 1;
    logic gntEnable = 1'b0;

    logic [31:0] expAddrQ[$];
    logic [31:0] expPcQ[$];
    logic [31:0] expInstrQ[$];

    fetch_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_gnt_i      (imem_gnt_i),
        .imem_rvalid_i   (imem_rvalid_i),
        .imem_rdata_i    (imem_rdata_i),
        .if_valid_o      (if_valid_o),
        .if_pc_o         (if_pc_o),
        .if_instr_o      (if_instr_o),
        .if_ready_i      (if_ready_i),
        .redirect_i      (redirect_i),
        .redirect_sel_i  (redirect_sel_i),
        .redirect_base_i (redirect_base_i),
        .redirect_imm_i  (redirect_imm_i),
        .redirect_alu_i  (redirect_alu_i),
        .misalign_o      (misalign_o),
        .halted_o        (halted_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic timeoutFail(input string name);
        tests++;
        fails++;
        $display("[TB] FAIL %s: timed out waiting", name);
    endtask

    // Memory model: grants while enabled and returns memWord(addr) after memLatency cycles.
    initial begin
        int pendCnt;
        logic [31:0] pendAddr;
        logic [31:0] grantAddr;
        pendCnt = 0;
        pendAddr = '0;
        grantAddr = '0;
        imem_gnt_i = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                pendCnt = 0;
                imem_rvalid_i = 1'b0;
                imem_gnt_i = 1'b0;
            end else begin
                imem_rvalid_i = 1'b0;
                if (imem_gnt_i) begin
                    pendAddr = grantAddr;
                    pendCnt = memLatency;
                end
                if (pendCnt > 0) begin
                    pendCnt--;
                    if (pendCnt == 0) begin
                        imem_rvalid_i = 1'b1;
                        imem_rdata_i = memWord(pendAddr);
                    end
                end
                imem_gnt_i = imem_req_o && gntEnable;
                grantAddr = imem_addr_o;
            end
        end
    end

    // Request monitor: every accepted request must match the next expected address.
    always @(negedge clk) begin
        if (!rst && imem_req_o && imem_gnt_i) begin
            reqCount++;
            if (expAddrQ.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL req_addr: unexpected request at %h, expected none", imem_addr_o);
            end else begin
                checkOutput("req_addr", imem_addr_o, expAddrQ.pop_front());
            end
        end
    end

    // Decode monitor: every accepted instruction must match the next expected pc/instr.
    always @(negedge clk) begin
        if (!rst && if_valid_o && if_ready_i && !redirect_i) begin
            instrCount++;
            if (expPcQ.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL if_pc: unexpected instruction pc %h, expected none", if_pc_o);
            end else begin
                checkOutput("if_pc", if_pc_o, expPcQ.pop_front());
                checkOutput("if_instr", if_instr_o, expInstrQ.pop_front());
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic expectFetch(input logic [31:0] a);
        expAddrQ.push_back(a);
    endtask

    task automatic expectInstr(input logic [31:0] a);
        expPcQ.push_back(a);
        expInstrQ.push_back(memWord(a));
    endtask

    task automatic waitReq(input int target, input string name);
        int n;
        n = 0;
        while (reqCount < target && n < 200) begin
            step(1);
            n++;
        end
        if (reqCount < target) timeoutFail(name);
    endtask

    task automatic waitInstr(input int target, input string name);
        int n;
        n = 0;
        while (instrCount < target && n < 200) begin
            step(1);
            n++;
        end
        if (instrCount < target) timeoutFail(name);
    endtask

    task automatic waitValid(input string name);
        int n;
        n = 0;
        while (!if_valid_o && n < 200) begin
            step(1);
            n++;
        end
        if (!if_valid_o) timeoutFail(name);
    endtask

    // Pulses a redirect for exactly one clock edge and returns just after that edge.
    task automatic applyStimulus(input logic sel, input logic [31:0] base, input logic [31:0] imm,
                                 input logic [31:0] alu);
        redirect_i = 1'b1;
        redirect_sel_i = sel;
        redirect_base_i = base;
        redirect_imm_i = imm;
        redirect_alu_i = alu;
        step(1);
        redirect_i = 1'b0;
    endtask

    // Watchdog so the run always ends on its own.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios: in-order fetch, slow memory with stall, redirects, halt, wrap and reset.
    initial begin
        rst = 1'b1;
        if_ready_i = 1'b1;
        redirect_i = 1'b0;
        redirect_sel_i = 1'b0;
        redirect_base_i = '0;
        redirect_imm_i = '0;
        redirect_alu_i = '0;
        memLatency = 1;
        gntEnable = 1'b1;
        #1;
        step(2);

        checkOutput("rst_req", 32'(imem_req_o), 32'd0);
        checkOutput("rst_addr", imem_addr_o, 32'h0);
        checkOutput("rst_valid", 32'(if_valid_o), 32'd0);
        checkOutput("rst_pc", if_pc_o, 32'h0);
        checkOutput("rst_instr", if_instr_o, 32'h0);
        checkOutput("rst_misalign", 32'(misalign_o), 32'd0);
        checkOutput("rst_halted", 32'(halted_o), 32'd0);
        rst = 1'b0;

        $display("[TB] scenario 1: sequential fetch with 1-cycle memory");
        expectFetch(32'h0); expectFetch(32'h4); expectFetch(32'h8);
        expectInstr(32'h0); expectInstr(32'h4); expectInstr(32'h8);
        waitReq(3, "seq_req");
        gntEnable = 1'b0;
        waitInstr(3, "seq_instr");

        $display("[TB] scenario 2: 3-cycle memory, decode stalled");
        memLatency = 3;
        if_ready_i = 1'b0;
        gntEnable = 1'b1;
        expectFetch(32'hC);
        waitValid("stall_valid");
        gntEnable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            checkOutput("stall_valid", 32'(if_valid_o), 32'd1);
            checkOutput("stall_pc", if_pc_o, 32'hC);
            checkOutput("stall_instr", if_instr_o, memWord(32'hC));
            checkOutput("stall_req", 32'(imem_req_o), 32'd0);
        end
        expectInstr(32'hC);
        if_ready_i = 1'b1;
        waitInstr(4, "stall_instr_accept");
        if_ready_i = 1'b0;

        $display("[TB] scenario 3: branch redirect while waiting");
        expectFetch(32'h10);
        gntEnable = 1'b1;
        waitReq(5, "wait_req10");
        memLatency = 1;
        expectFetch(32'h30);
        applyStimulus(1'b0, 32'h10, 32'h20, 32'h0);
        checkOutput("wait_redir_req", 32'(imem_req_o), 32'd0);
        waitReq(6, "wait_req30");
        gntEnable = 1'b0;
        waitValid("wait_valid30");
        checkOutput("wait_pc30", if_pc_o, 32'h30);
        checkOutput("wait_instr30", if_instr_o, memWord(32'h30));

        $display("[TB] scenario 4: JALR redirect in hold with ready high");
        if_ready_i = 1'b1;
        gntEnable = 1'b1;
        expectFetch(32'h40);
        expectInstr(32'h40);
        applyStimulus(1'b1, 32'h0, 32'h0, 32'h41);
        checkOutput("hold_redir_valid", 32'(if_valid_o), 32'd0);
        checkOutput("hold_redir_req", 32'(imem_req_o), 32'd1);
        checkOutput("hold_redir_addr", imem_addr_o, 32'h40);
        waitReq(7, "hold_req40");
        gntEnable = 1'b0;
        waitInstr(5, "hold_instr40");

        $display("[TB] scenario 5: misaligned redirect halts");
        applyStimulus(1'b0, 32'h100, 32'h2, 32'h0);
        checkOutput("mis_pulse", 32'(misalign_o), 32'd1);
        checkOutput("mis_halted", 32'(halted_o), 32'd1);
        checkOutput("mis_req", 32'(imem_req_o), 32'd0);
        checkOutput("mis_valid", 32'(if_valid_o), 32'd0);
        step(1);
        checkOutput("mis_pulse_end", 32'(misalign_o), 32'd0);
        gntEnable = 1'b1;
        applyStimulus(1'b0, 32'h80, 32'h0, 32'h0);
        checkOutput("halt_addr", imem_addr_o, 32'h44);
        for (int i = 0; i < 4; i++) begin
            step(1);
            checkOutput("halt_req", 32'(imem_req_o), 32'd0);
            checkOutput("halt_flag", 32'(halted_o), 32'd1);
        end

        $display("[TB] scenario 6: PC wrap and reset during wait");
        rst = 1'b1;
        gntEnable = 1'b0;
        step(2);
        rst = 1'b0;
        checkOutput("rst2_halted", 32'(halted_o), 32'd0);
        memLatency = 3;
        gntEnable = 1'b1;
        expectFetch(32'hFFFF_FFFC);
        expectFetch(32'h0);
        expectInstr(32'hFFFF_FFFC);
        applyStimulus(1'b0, 32'hFFFF_FFF0, 32'hC, 32'h0);
        checkOutput("wrap_addr", imem_addr_o, 32'hFFFF_FFFC);
        waitReq(9, "wrap_req0");
        rst = 1'b1;
        memLatency = 1;
        expectFetch(32'h0);
        expectInstr(32'h0);
        step(1);
        rst = 1'b0;
        checkOutput("rst3_req", 32'(imem_req_o), 32'd0);
        checkOutput("rst3_valid", 32'(if_valid_o), 32'd0);
        step(1);
        checkOutput("rst3_req_up", 32'(imem_req_o), 32'd1);
        checkOutput("rst3_addr", imem_addr_o, 32'h0);
        waitReq(10, "rst3_refetch");
        gntEnable = 1'b0;
        waitInstr(7, "rst3_instr");
        step(3);

        checkOutput("addr_queue_drained", 32'(expAddrQ.size()), 32'd0);
        checkOutput("instr_queue_drained", 32'(expPcQ.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
